// File: rtl/wb_pkg.sv
// Shared writeback-stage types: issue kinds, result-mux selects, FSM states.
package wb_pkg;

   typedef enum logic [1:0] {
      KIND_ALU  = 2'b00,
      KIND_LOAD = 2'b01,
      KIND_LINK = 2'b10,
      KIND_NONE = 2'b11
   } kind_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } resultsrc_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } state_e;

   localparam int TMR_W = 16;

endpackage

// File: rtl/wb_timeout_timer.sv
// Wait timer: counts enabled cycles from a clear and flags the last allowed cycle.
module wb_timeout_timer
   import wb_pkg::*;
#(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   assign expired = (cnt_q == TMR_W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: registers result operands, drives the result-mux
// select and regfile write, and stalls the front end on outstanding loads.
module wb_sched
   import wb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [1:0]       issue_kind,
   input  logic [4:0]       issue_rd,
   input  logic [XLEN-1:0]  issue_alu,
   input  logic [XLEN-1:0]  issue_pc4,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic [1:0]       wb_resultsrc,
   output logic             wb_regwrite,
   output logic [4:0]       wb_rd,
   output logic [XLEN-1:0]  wb_d0,
   output logic [XLEN-1:0]  wb_d1,
   output logic [XLEN-1:0]  wb_d2,
   output logic             stall,
   output logic             err_timeout,
   output logic             err_spurious,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e            state_q, state_d;
   logic [4:0]        pend_q, pend_d;
   logic [XLEN-1:0]   d0_q, d0_d;
   logic [XLEN-1:0]   d1_q, d1_d;
   logic [XLEN-1:0]   d2_q, d2_d;
   resultsrc_e        res_q, res_d;
   logic [4:0]        rd_q, rd_d;
   logic              we_q, we_d;
   logic              to_q, to_d;
   logic              sp_q, sp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tmr_clr;
   logic              tmr_en;
   logic              tmr_exp;
   kind_e             kind;

   assign kind = kind_e'(issue_kind);

   assign issue_ready  = (state_q == ST_IDLE);
   assign stall        = (state_q == ST_LOAD_WAIT);
   assign wb_resultsrc = res_q;
   assign wb_regwrite  = we_q;
   assign wb_rd        = rd_q;
   assign wb_d0        = d0_q;
   assign wb_d1        = d1_q;
   assign wb_d2        = d2_q;
   assign err_timeout  = to_q;
   assign err_spurious = sp_q;
   assign stall_cnt    = cnt_q;

   assign tmr_en = (state_q == ST_LOAD_WAIT) && !mem_rvalid;

   wb_timeout_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clr),
      .enable  (tmr_en),
      .expired (tmr_exp)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      res_d   = res_q;
      rd_d    = rd_q;
      we_d    = 1'b0;
      to_d    = 1'b0;
      sp_d    = 1'b0;
      cnt_d   = cnt_q;
      tmr_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            sp_d = mem_rvalid;
            if (issue_valid) begin
               d0_d = issue_alu;
               d2_d = issue_pc4;
               unique case (kind)
                  KIND_ALU: begin
                     res_d = RES_ALU;
                     rd_d  = issue_rd;
                     we_d  = |issue_rd;
                  end
                  KIND_LINK: begin
                     res_d = RES_PC4;
                     rd_d  = issue_rd;
                     we_d  = |issue_rd;
                  end
                  KIND_NONE: begin
                     res_d = RES_ALU;
                     rd_d  = 5'd0;
                  end
                  KIND_LOAD: begin
                     state_d = ST_LOAD_WAIT;
                     pend_d  = issue_rd;
                     tmr_clr = 1'b1;
                  end
               endcase
            end
         end
         ST_LOAD_WAIT: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Data arriving on the expiry cycle takes priority over the abort.
            if (mem_rvalid) begin
               d1_d    = mem_rdata;
               res_d   = RES_MEM;
               rd_d    = pend_q;
               we_d    = |pend_q;
               state_d = ST_IDLE;
            end else if (tmr_exp) begin
               to_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         res_q   <= RES_ALU;
         rd_q    <= '0;
         we_q    <= 1'b0;
         to_q    <= 1'b0;
         sp_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         to_q    <= to_d;
         sp_q    <= sp_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_sched.sv
// Directed self-checking bench for wb_sched (TIMEOUT = 4).
module tb_wb_sched;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 16;

   logic             clk;
   logic             rst_n;
   logic             issue_valid;
   logic             issue_ready;
   logic [1:0]       issue_kind;
   logic [4:0]       issue_rd;
   logic [XLEN-1:0]  issue_alu;
   logic [XLEN-1:0]  issue_pc4;
   logic             mem_rvalid;
   logic [XLEN-1:0]  mem_rdata;
   logic [1:0]       wb_resultsrc;
   logic             wb_regwrite;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_d0;
   logic [XLEN-1:0]  wb_d1;
   logic [XLEN-1:0]  wb_d2;
   logic             stall;
   logic             err_timeout;
   logic             err_spurious;
   logic [CNT_W-1:0] stall_cnt;

   int n_checks;
   int n_fail;

   wb_sched #(
      .XLEN    (XLEN),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_kind   (issue_kind),
      .issue_rd     (issue_rd),
      .issue_alu    (issue_alu),
      .issue_pc4    (issue_pc4),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .wb_resultsrc (wb_resultsrc),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .wb_d0        (wb_d0),
      .wb_d1        (wb_d1),
      .wb_d2        (wb_d2),
      .stall        (stall),
      .err_timeout  (err_timeout),
      .err_spurious (err_spurious),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic issue(input logic [1:0] k, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc4);
      issue_valid = 1'b1;
      issue_kind  = k;
      issue_rd    = rd;
      issue_alu   = alu;
      issue_pc4   = pc4;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0;
      issue_kind  = 2'b11;
      issue_rd    = 5'd0;
      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      issue_alu = '0;
      issue_pc4 = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (issue_ready !== 1'b1 || wb_regwrite !== 1'b0 || stall !== 1'b0 ||
          wb_resultsrc !== 2'b00 || wb_rd !== 5'd0 || wb_d0 !== 32'h0 ||
          wb_d1 !== 32'h0 || wb_d2 !== 32'h0 || err_timeout !== 1'b0 ||
          err_spurious !== 1'b0 || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset: ready=%b we=%b stall=%b res=%b rd=%0d cnt=%0d, want ready=1 others 0",
                  issue_ready, wb_regwrite, stall, wb_resultsrc, wb_rd, stall_cnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alu();
      issue(2'b00, 5'd5, 32'h0000_1234, 32'h0000_0008);
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (wb_resultsrc !== 2'b00 || wb_regwrite !== 1'b1 || wb_rd !== 5'd5 ||
          wb_d0 !== 32'h1234 || wb_d2 !== 32'h8 || issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL alu: res=%b we=%b rd=%0d d0=%h d2=%h ready=%b, want 00 1 5 1234 8 1",
                  wb_resultsrc, wb_regwrite, wb_rd, wb_d0, wb_d2, issue_ready);
      end
      @(negedge clk);
      n_checks++;
      if (wb_regwrite !== 1'b0 || wb_rd !== 5'd5) begin
         n_fail++;
         $display("FAIL alu_pulse: we=%b rd=%0d, want 0 5", wb_regwrite, wb_rd);
      end
   endtask

   task automatic test_back_to_back();
      issue(2'b10, 5'd1, 32'h0000_0055, 32'h0000_0104);
      @(negedge clk);
      n_checks++;
      if (wb_resultsrc !== 2'b10 || wb_regwrite !== 1'b1 || wb_rd !== 5'd1 ||
          wb_d2 !== 32'h104 || wb_d0 !== 32'h55) begin
         n_fail++;
         $display("FAIL link: res=%b we=%b rd=%0d d2=%h d0=%h, want 10 1 1 104 55",
                  wb_resultsrc, wb_regwrite, wb_rd, wb_d2, wb_d0);
      end
      issue(2'b00, 5'd0, 32'h0000_0077, 32'h0000_0108);
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (wb_regwrite !== 1'b0 || wb_resultsrc !== 2'b00 || wb_rd !== 5'd0 ||
          wb_d0 !== 32'h77 || wb_d2 !== 32'h108) begin
         n_fail++;
         $display("FAIL alu_x0: we=%b res=%b rd=%0d d0=%h d2=%h, want 0 00 0 77 108",
                  wb_regwrite, wb_resultsrc, wb_rd, wb_d0, wb_d2);
      end
      issue(2'b11, 5'd9, 32'h0000_00AA, 32'h0000_010C);
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (wb_regwrite !== 1'b0 || wb_resultsrc !== 2'b00 || wb_rd !== 5'd0 ||
          wb_d0 !== 32'hAA || wb_d2 !== 32'h10C || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL none: we=%b res=%b rd=%0d d0=%h d2=%h stall=%b, want 0 00 0 aa 10c 0",
                  wb_regwrite, wb_resultsrc, wb_rd, wb_d0, wb_d2, stall);
      end
   endtask

   task automatic test_load();
      issue(2'b01, 5'd7, 32'h0000_0100, 32'h0000_0110);
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (stall !== 1'b1 || issue_ready !== 1'b0 || wb_regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wait%0d: stall=%b ready=%b we=%b, want 1 0 0",
                     i, stall, issue_ready, wb_regwrite);
         end
         if (i == 2) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
         end
         @(negedge clk);
      end
      idle_inputs();
      n_checks++;
      if (wb_resultsrc !== 2'b01 || wb_d1 !== 32'hDEAD_BEEF || wb_rd !== 5'd7 ||
          wb_regwrite !== 1'b1 || stall !== 1'b0 || stall_cnt !== 16'd3 ||
          err_spurious !== 1'b0) begin
         n_fail++;
         $display("FAIL load_wb: res=%b d1=%h rd=%0d we=%b stall=%b cnt=%0d sp=%b, want 01 deadbeef 7 1 0 3 0",
                  wb_resultsrc, wb_d1, wb_rd, wb_regwrite, stall, stall_cnt, err_spurious);
      end
   endtask

   task automatic test_timeout();
      issue(2'b01, 5'd9, 32'h0, 32'h0000_0200);
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (stall !== 1'b1 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_wait%0d: stall=%b err=%b, want 1 0", i, stall, err_timeout);
         end
         @(negedge clk);
      end
      n_checks++;
      if (err_timeout !== 1'b1 || stall !== 1'b0 || wb_regwrite !== 1'b0 ||
          issue_ready !== 1'b1 || stall_cnt !== 16'd7) begin
         n_fail++;
         $display("FAIL timeout: err=%b stall=%b we=%b ready=%b cnt=%0d, want 1 0 0 1 7",
                  err_timeout, stall, wb_regwrite, issue_ready, stall_cnt);
      end
      issue(2'b00, 5'd2, 32'h0000_00A2, 32'h0000_0204);
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (err_timeout !== 1'b0 || wb_regwrite !== 1'b1 || wb_rd !== 5'd2 ||
          wb_d0 !== 32'hA2 || wb_d1 !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL after_to: err=%b we=%b rd=%0d d0=%h d1=%h, want 0 1 2 a2 deadbeef",
                  err_timeout, wb_regwrite, wb_rd, wb_d0, wb_d1);
      end
   endtask

   task automatic test_rvalid_wins();
      issue(2'b01, 5'd12, 32'h0, 32'h0000_0300);
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_0001;
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (err_timeout !== 1'b0 || wb_regwrite !== 1'b1 || wb_rd !== 5'd12 ||
          wb_resultsrc !== 2'b01 || wb_d1 !== 32'hCAFE_0001 ||
          stall_cnt !== 16'd11) begin
         n_fail++;
         $display("FAIL rvalid_wins: err=%b we=%b rd=%0d res=%b d1=%h cnt=%0d, want 0 1 12 01 cafe0001 11",
                  err_timeout, wb_regwrite, wb_rd, wb_resultsrc, wb_d1, stall_cnt);
      end
      @(negedge clk);
      n_checks++;
      if (err_timeout !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rvalid_wins_late: err=%b stall=%b, want 0 0", err_timeout, stall);
      end
   endtask

   task automatic test_spurious();
      issue(2'b00, 5'd3, 32'h0000_0333, 32'h0000_0400);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_1111;
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (err_spurious !== 1'b1 || wb_regwrite !== 1'b1 || wb_rd !== 5'd3 ||
          wb_d0 !== 32'h333 || wb_d1 !== 32'hCAFE_0001 || wb_resultsrc !== 2'b00) begin
         n_fail++;
         $display("FAIL spurious: sp=%b we=%b rd=%0d d0=%h d1=%h res=%b, want 1 1 3 333 cafe0001 00",
                  err_spurious, wb_regwrite, wb_rd, wb_d0, wb_d1, wb_resultsrc);
      end
      @(negedge clk);
      n_checks++;
      if (err_spurious !== 1'b0 || wb_regwrite !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious_pulse: sp=%b we=%b, want 0 0", err_spurious, wb_regwrite);
      end
   endtask

   task automatic test_reset_mid_load();
      issue(2'b01, 5'd4, 32'h0, 32'h0000_0500);
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_load_enter: stall=%b, want 1", stall);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || wb_regwrite !== 1'b0 || err_timeout !== 1'b0 ||
          stall_cnt !== 16'd0 || issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid: stall=%b we=%b err=%b cnt=%0d ready=%b, want 0 0 0 0 1",
                  stall, wb_regwrite, err_timeout, stall_cnt, issue_ready);
      end
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_0099;
      @(negedge clk);
      idle_inputs();
      n_checks++;
      if (wb_regwrite !== 1'b0 || err_spurious !== 1'b1 || stall !== 1'b0 ||
          stall_cnt !== 16'd0 || wb_d1 !== 32'h0 || err_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_late: we=%b sp=%b stall=%b cnt=%0d d1=%h err=%b, want 0 1 0 0 0 0",
                  wb_regwrite, err_spurious, stall, stall_cnt, wb_d1, err_timeout);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_alu();
      test_back_to_back();
      test_load();
      test_timeout();
      test_rvalid_wins();
      test_spurious();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
